cube_serial_receiver: RTL

- Receive-side counterpart of the cube panel driver. Deserializes the 12-lane (4 red, 4 green, 4 blue) shift-register stream using serial_clk, latch_enable and output_enable_n, and captures the active-low row select.
- Presents one captured row word per latch event with protocol error flags.
- Used as the input stage of a daisy-chained slave cube board and as the loopback checker on the bench.

---
 rtl/cube_rx_pkg.sv | 40 ++++
 rtl/cube_sync_edge.sv | 37 +++
 rtl/cube_serial_receiver.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cube_rx_pkg.sv
// Shared types and constants for the cube panel serial receiver.
package cube_rx_pkg;

    localparam int LANES_DEF = 4;
    localparam int BITS_DEF  = 16;
    localparam int ROWS_DEF  = 16;
    localparam int COLOURS   = 3;
    localparam int MAX_ROWS  = 256;
    localparam int ROW_IDX_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

    typedef struct packed {
        logic                 valid;
        logic [ROW_IDX_W-1:0] index;
    } row_decode_t;

    // Callers pad unused upper bits with 1s so they never count as selected rows.
    function automatic row_decode_t decode_one_hot_low(input logic [MAX_ROWS-1:0] sel_n);
        row_decode_t res;
        int          zeros;
        res   = '0;
        zeros = 0;
        for (int i = 0; i < MAX_ROWS; i++) begin
            if (!sel_n[i]) begin
                zeros++;
                res.index = ROW_IDX_W'(i);
            end
        end
        res.valid = (zeros == 1);
        if (!res.valid) begin
            res.index = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/cube_sync_edge.sv
// Multi-flop synchronizer with a per-bit rising-edge strobe on the synchronized output.
module cube_sync_edge #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_rise
);

    localparam int NS = (STAGES < 2) ? 2 : STAGES;

    logic [WIDTH-1:0] r_sync [NS];
    logic [WIDTH-1:0] r_dly;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                r_sync[s] <= RESET_VAL;
            end
            r_dly <= RESET_VAL;
        end else begin
            r_sync[0] <= i_d;
            for (int s = 1; s < NS; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_dly <= r_sync[NS-1];
        end
    end

    assign o_q    = r_sync[NS-1];
    assign o_rise = r_sync[NS-1] & ~r_dly;

endmodule

// File: rtl/cube_serial_receiver.sv
// Deserializer for the 12-lane cube panel stream with row decode and protocol error flags.
// Optional blanking check enabled by defining CUBE_RX_BLANK_CHECK_EN.
module cube_serial_receiver
    import cube_rx_pkg::*;
#(
    parameter int LANES          = LANES_DEF,
    parameter int BITS_PER_LATCH = BITS_DEF,
    parameter int SYNC_STAGES    = 2,
    parameter int ROWS           = ROWS_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              serial_clk,
    input  logic                              latch_enable,
    input  logic                              output_enable_n,
    input  logic [LANES-1:0]                  serial_data_in_red,
    input  logic [LANES-1:0]                  serial_data_in_green,
    input  logic [LANES-1:0]                  serial_data_in_blue,
    input  logic [ROWS-1:0]                   row_select_n,
    output logic [LANES*BITS_PER_LATCH-1:0]   row_data_red,
    output logic [LANES*BITS_PER_LATCH-1:0]   row_data_green,
    output logic [LANES*BITS_PER_LATCH-1:0]   row_data_blue,
    output logic [$clog2(ROWS)-1:0]           row_index,
    output logic                              row_valid,
    output logic                              bit_count_error,
    output logic                              row_select_error,
    output logic                              blanking_error
);

    localparam int B   = BITS_PER_LATCH;
    localparam int NL  = COLOURS * LANES;
    localparam int CW  = $clog2(B + 1) + 1;
    localparam int RIW = $clog2(ROWS);
    localparam int WW  = LANES * B;

    localparam logic [CW-1:0] CNT_FULL = CW'(B);
    localparam logic [CW-1:0] CNT_SAT  = CW'(B + 1);

    logic            w_sclk_q;
    logic            w_sclk_rise;
    logic            w_latch_q;
    logic            w_latch_rise;
    logic [NL-1:0]   w_lanes_in;
    logic [NL-1:0]   w_lanes;
    logic [NL-1:0]   w_lanes_rise;
    logic [ROWS-1:0] w_row_sync;
    logic [ROWS-1:0] w_row_rise;

    cube_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .reset  (reset),
        .i_d    (serial_clk),
        .o_q    (w_sclk_q),
        .o_rise (w_sclk_rise)
    );

    cube_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_latch (
        .clk    (clk),
        .reset  (reset),
        .i_d    (latch_enable),
        .o_q    (w_latch_q),
        .o_rise (w_latch_rise)
    );

    // Lane index = colour*LANES + lane, red first.
    assign w_lanes_in = {serial_data_in_blue, serial_data_in_green, serial_data_in_red};

    cube_sync_edge #(.WIDTH(NL), .STAGES(SYNC_STAGES), .RESET_VAL('0)) u_sync_lanes (
        .clk    (clk),
        .reset  (reset),
        .i_d    (w_lanes_in),
        .o_q    (w_lanes),
        .o_rise (w_lanes_rise)
    );

    cube_sync_edge #(.WIDTH(ROWS), .STAGES(SYNC_STAGES), .RESET_VAL('1)) u_sync_rows (
        .clk    (clk),
        .reset  (reset),
        .i_d    (row_select_n),
        .o_q    (w_row_sync),
        .o_rise (w_row_rise)
    );

    rx_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic [B-1:0]    r_shift [NL];
    logic [WW-1:0]   r_data_red;
    logic [WW-1:0]   r_data_green;
    logic [WW-1:0]   r_data_blue;
    logic [RIW-1:0]  r_row_index;
    logic            r_row_valid;
    logic            r_bit_count_error;
    logic            r_row_select_error;

    logic [B-1:0]        w_shift_next [NL];
    logic [CW-1:0]       w_cnt_next;
    logic                w_have_bits;
    logic [MAX_ROWS-1:0] w_sel_pad;
    row_decode_t         w_dec;
    logic                w_row_ok;

    // The shift is folded in ahead of the latch so a coincident bit is included.
    always_comb begin
        for (int l = 0; l < NL; l++) begin
            w_shift_next[l] = w_sclk_rise ? {r_shift[l][B-2:0], w_lanes[l]} : r_shift[l];
        end
        w_cnt_next  = (w_sclk_rise && (r_cnt != CNT_SAT)) ? r_cnt + 1'b1 : r_cnt;
        w_have_bits = (r_state == ST_SHIFT) || w_sclk_rise;
    end

    always_comb begin
        w_sel_pad              = '1;
        w_sel_pad[ROWS-1:0]    = w_row_sync;
        w_dec                  = decode_one_hot_low(w_sel_pad);
        w_row_ok               = w_dec.valid && (int'(w_dec.index) < ROWS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= ST_IDLE;
            r_cnt              <= '0;
            for (int l = 0; l < NL; l++) begin
                r_shift[l] <= '0;
            end
            r_data_red         <= '0;
            r_data_green       <= '0;
            r_data_blue        <= '0;
            r_row_index        <= '0;
            r_row_valid        <= 1'b0;
            r_bit_count_error  <= 1'b0;
            r_row_select_error <= 1'b0;
        end else begin
            r_row_valid <= 1'b0;
            if (w_latch_rise) begin
                for (int i = 0; i < LANES; i++) begin
                    r_data_red[i*B +: B]   <= w_have_bits ? w_shift_next[i]           : '0;
                    r_data_green[i*B +: B] <= w_have_bits ? w_shift_next[LANES+i]     : '0;
                    r_data_blue[i*B +: B]  <= w_have_bits ? w_shift_next[2*LANES+i]   : '0;
                end
                for (int l = 0; l < NL; l++) begin
                    r_shift[l] <= '0;
                end
                r_row_index        <= w_row_ok ? w_dec.index[RIW-1:0] : '0;
                r_row_select_error <= !w_row_ok;
                r_bit_count_error  <= (w_cnt_next != CNT_FULL);
                r_row_valid        <= 1'b1;
                r_cnt              <= '0;
                r_state            <= ST_IDLE;
            end else if (w_sclk_rise) begin
                for (int l = 0; l < NL; l++) begin
                    r_shift[l] <= w_shift_next[l];
                end
                r_cnt   <= w_cnt_next;
                r_state <= ST_SHIFT;
            end
        end
    end

`ifdef CUBE_RX_BLANK_CHECK_EN
    logic w_oen_q;
    logic w_oen_rise;
    logic r_blanking_error;

    cube_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_oen (
        .clk    (clk),
        .reset  (reset),
        .i_d    (output_enable_n),
        .o_q    (w_oen_q),
        .o_rise (w_oen_rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blanking_error <= 1'b0;
        end else if (w_latch_rise) begin
            r_blanking_error <= !w_oen_q;
        end
    end

    assign blanking_error = r_blanking_error;
`else
    assign blanking_error = 1'b0;
`endif

    assign row_data_red     = r_data_red;
    assign row_data_green   = r_data_green;
    assign row_data_blue    = r_data_blue;
    assign row_index        = r_row_index;
    assign row_valid        = r_row_valid;
    assign bit_count_error  = r_bit_count_error;
    assign row_select_error = r_row_select_error;

endmodule
